// File: rtl/iob_arbiter_rr.sv
// -----------------------------------------------------------------------------
// iob_arbiter_rr
//   Round-robin arbiter with a registered one-hot grant and an optional
//   hold-time limit. A grant is issued from IDLE to the first requester found
//   scanning up from the rotating pointer. It is then held until the owner
//   signals done_i, drops its request, or holds it for TIMEOUT cycles. Every
//   release goes back through IDLE and moves the pointer just past the
//   released owner.
//
// Parameters
//   N        number of requesters (2..32)
//   N_W      width of the grant index
//   TIMEOUT  maximum grant hold in cycles, 0 = unlimited
//   TMO_W    hold-counter width
//
// Ports
//   clk_i          system clock, rising edge
//   arst_n_i       asynchronous active-low reset
//   cke_i          clock enable; all state holds while low
//   rst_i          synchronous clear, qualified by cke_i, highest priority
//   req_i          per-requester request levels
//   done_i         current owner releases the resource this cycle
//   grant_o        one-hot grant, zero when idle
//   grant_id_o     index of the current owner, zero when idle
//   grant_valid_o  high while a grant is held
//   timeout_o      one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module iob_arbiter_rr #(
  parameter int N       = 4,
  parameter int N_W     = $clog2(N),
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  input  logic           cke_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic           done_i,
  output logic [N-1:0]   grant_o,
  output logic [N_W-1:0] grant_id_o,
  output logic           grant_valid_o,
  output logic           timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit             TMO_EN   = (TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [N_W:0]   SUM_N    = (N_W + 1)'(N);

  state_t           state_q, state_d;
  logic [N_W-1:0]   ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N_W-1:0]   id_q, id_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  // Round-robin pick: rotate the requests so the pointer lands on bit 0, find
  // the lowest set bit, then add the pointer back modulo N.
  logic [2*N-1:0]   rot2;
  logic [N-1:0]     rot;
  logic             pick_found;
  logic [N_W-1:0]   pick_off;
  logic [N_W:0]     pick_sum;
  logic [N_W-1:0]   pick_id;

  always_comb begin
    rot2       = {req_i, req_i} >> ptr_q;
    rot        = rot2[N-1:0];
    pick_found = |rot;
    pick_off   = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pick_off = N_W'(i);
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    pick_id  = (pick_sum >= SUM_N) ? N_W'(pick_sum - SUM_N) : pick_sum[N_W-1:0];
  end

  // Release conditions while BUSY. The owner's request is read through the
  // registered one-hot grant, which avoids indexing req_i by the owner id.
  logic owner_req;
  logic tmo_hit;
  logic [N_W-1:0] next_ptr;

  assign owner_req = |(req_i & grant_q);
  assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST);
  assign next_ptr  = (id_q == N_W'(N - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;

    if (rst_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      id_d    = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // done_i has no meaning without an owner and is ignored here.
          if (pick_found) begin
            state_d = BUSY;
            id_d    = pick_id;
            valid_d = 1'b1;
            cnt_d   = '0;
          end
        end
        BUSY: begin
          if (done_i || !owner_req || tmo_hit) begin
            state_d = IDLE;
            id_d    = '0;
            valid_d = 1'b0;
            ptr_d   = next_ptr;
            // A simultaneous done_i or request drop is an ordinary release.
            tmo_d   = tmo_hit && !done_i && owner_req;
          end else if (TMO_EN) begin
            // Staying BUSY implies cnt_q < TMO_LAST, so this never wraps.
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    grant_d = valid_d ? (N'(1) << id_d) : '0;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (cke_i) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = valid_q;
  assign timeout_o     = tmo_q;

endmodule

// File: doc/iob_arbiter_rr.md
IOB_ARBITER_RR -- requirements
Module: iob_arbiter_rr

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..32.
REQ-002 Parameter N_W, default $clog2(N): width of the grant index.
REQ-003 Parameter TIMEOUT, default 16: maximum grant hold in cycles; 0 disables the timeout.
REQ-004 Parameter TMO_W, default $clog2(TIMEOUT+1), minimum 1: hold-counter width.
REQ-005 clk_i  input  1  system clock; the block uses only rising edges.
REQ-006 arst_n_i  input  1  asynchronous, active-low reset.
REQ-007 cke_i  input  1  clock enable; when 0, all state holds.
REQ-008 rst_i  input  1  synchronous clear, active-high, qualified by cke_i.
REQ-009 req_i  input  N  per-requester request level.
REQ-010 done_i  input  1  current owner releases the resource this cycle.
REQ-011 grant_o  output  N  one-hot registered grant; all-zero when idle.
REQ-012 grant_id_o  output  N_W  index of the current owner; 0 when idle.
REQ-013 grant_valid_o  output  1  high while any grant is held.
REQ-014 timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-016 All outputs SHALL be registered, and the state, outputs, pointer and counter SHALL update only on rising clk_i edges with cke_i=1.
REQ-017 In IDLE, if req_i is non-zero, the FSM SHALL select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1, then enter BUSY.
REQ-018 Grant latency: req_i sampled high at edge k SHALL produce grant_o, grant_id_o and grant_valid_o at edge k+1.
REQ-019 In IDLE with req_i=0, the FSM SHALL stay in IDLE with all grant outputs at 0.
REQ-020 In BUSY, the grant SHALL be held unchanged regardless of other requesters' req_i.
REQ-021 The FSM SHALL exit BUSY on whichever of these occurs first: (a) done_i=1, (b) req_i[grant_id_o]=0, (c) the hold counter reaches TIMEOUT-1 with TIMEOUT>0.
REQ-022 On a BUSY exit, the grant outputs SHALL clear at the next edge and the FSM SHALL enter IDLE.
REQ-023 Back-to-back grants SHALL therefore be separated by at least one idle cycle.
REQ-024 On each BUSY exit, ptr SHALL become (grant_id_o+1) mod N; ptr SHALL otherwise hold.
REQ-025 The hold counter SHALL load 0 on entry to BUSY and increment by 1 per enabled cycle in BUSY.
REQ-026 The hold counter SHALL never wrap: it is compared for equality to TIMEOUT-1, and BUSY exits on that match.
REQ-027 TIMEOUT=1 SHALL give a one-cycle grant.
REQ-028 timeout_o SHALL be 1 for exactly one cycle, coincident with the grant clearing, only when exit is caused by (c) and neither (a) nor (b) holds in that cycle.
REQ-029 If done_i and the timeout fire in the same cycle, the exit SHALL be treated as done_i and timeout_o SHALL remain 0.
REQ-030 done_i SHALL be ignored in IDLE.
REQ-031 grant_o SHALL always equal the one-hot decode of grant_id_o when grant_valid_o=1, and SHALL be all-zero otherwise.
REQ-032 With cke_i=0, the FSM SHALL hold every state and output, including a timeout_o pulse already asserted, and the counter SHALL not advance.

Reset
REQ-033 While arst_n_i=0: state=IDLE, ptr=0, counter=0, grant_o=0, grant_id_o=0, grant_valid_o=0, timeout_o=0, independent of clk_i.
REQ-034 rst_i=1 with cke_i=1 SHALL force the same values as REQ-033 at the next edge, including mid-grant, with no timeout_o pulse.
REQ-035 rst_i SHALL have priority over all other inputs.
REQ-036 rst_i with cke_i=0 SHALL have no effect.
REQ-037 Deassertion of arst_n_i SHALL cause no grant before the first enabled edge that samples req_i.

Verification
REQ-038 N=4, req_i=4'b1111 held, done_i pulsed one cycle after each grant -> grant_id_o sequence 0,1,2,3,0, with one idle cycle between grants.
REQ-039 ptr=2 (after a grant to 1), req_i=4'b0011 -> next grant_id_o=0, because 2 and 3 are skipped and the scan wraps.
REQ-040 TIMEOUT=16, single requester 3 held, done_i=0 -> grant_valid_o high for exactly 16 cycles, timeout_o pulses once, then the requester is re-granted after one idle cycle.
REQ-041 done_i asserted on the same cycle the counter reaches 15 -> grant clears with timeout_o=0.
REQ-042 Grant to 1 active, arst_n_i pulsed low mid-cycle -> all outputs 0 immediately; after release, req_i=4'b0010 -> grant_id_o=1 one edge later (ptr=0).
REQ-043 Grant held, cke_i=0 for 10 cycles with done_i=1 -> grant unchanged and counter frozen; cke_i=1 -> grant clears at the next edge.
